// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared RV64I decode definitions: base opcode values, instruction format
// classes and the decoded-instruction bundle handed to execute.
// No ports (package).
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    // PC is carried beside this bundle because its width is a parameter of
    // the decoder rather than a fixed architectural constant.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        fmt_e        fmt;
        logic [63:0] imm;
        logic        illegal;
    } decoded_t;

endpackage

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
// Synchronous FIFO of fetched {pc, inst} words sitting between fetch and the
// decoder output slot.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            empties the queue (same effect as reset)
//   push, wdata      write wdata at the tail (ignored when full)
//   pop              drop the head entry (ignored when empty)
//   rdata            head entry (valid when !empty)
//   count            number of stored entries, 0..DEPTH
//   full, empty      status from the registered count
// ----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_decoder.sv
// ----------------------------------------------------------------------------
// inst_decoder
// RV64I decode stage: queues fetched words, cracks the head into register
// fields, format class and sign-extended immediate, and presents the result
// in a registered valid/ready output slot.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard queue and output slot (redirect)
//   in_valid/in_ready     fetch handshake; in_ready = queue count < DEPTH
//   in_addr, in_inst      PC and raw instruction word
//   out_valid/out_ready   execute handshake on the output slot
//   out_pc .. out_illegal decoded instruction fields
// ----------------------------------------------------------------------------
module inst_decoder
    import riscv_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_inst,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [6:0]            out_opcode,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [2:0]            out_funct3,
    output logic [6:0]            out_funct7,
    output logic [2:0]            out_fmt,
    output logic [63:0]           out_imm,
    output logic                  out_illegal
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = ADDR_WIDTH + 32;

    function automatic decoded_t decode(input logic [31:0] inst);
        decoded_t d;
        d.opcode  = inst[6:0];
        d.rd      = inst[11:7];
        d.rs1     = inst[19:15];
        d.rs2     = inst[24:20];
        d.funct3  = inst[14:12];
        d.funct7  = inst[31:25];
        d.fmt     = FMT_ILL;
        d.imm     = '0;
        d.illegal = 1'b0;
        case (inst[6:0])
            OP, OP_32: d.fmt = FMT_R;
            OP_IMM, OP_IMM_32, LOAD, JALR, SYSTEM, MISC_MEM: begin
                d.fmt = FMT_I;
                d.imm = {{52{inst[31]}}, inst[31:20]};
            end
            STORE: begin
                d.fmt = FMT_S;
                d.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            end
            BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25],
                         inst[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            end
            JAL: begin
                d.fmt = FMT_J;
                d.imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20],
                         inst[30:21], 1'b0};
            end
            default: begin
                d.fmt     = FMT_ILL;
                d.illegal = 1'b1;
            end
        endcase
        // An all-zero word is the canonical illegal instruction.
        if (inst == 32'd0) begin
            d.fmt     = FMT_ILL;
            d.imm     = '0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    logic [QW-1:0]         head_word;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [31:0]           head_inst;
    logic [CW-1:0]         q_count;
    logic                  q_full;
    logic                  q_empty;
    logic                  push;
    logic                  load;
    decoded_t              dec_q;

    assign in_ready  = (q_count < CW'(DEPTH));
    assign push      = in_valid && !q_full;
    assign load      = !q_empty && (!out_valid || out_ready);
    assign head_pc   = head_word[QW-1:32];
    assign head_inst = head_word[31:0];

    inst_queue #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata ({in_addr, in_inst}),
        .pop   (load),
        .rdata (head_word),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            dec_q     <= '0;
            dec_q.fmt <= FMT_ILL;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pc    <= head_pc;
            dec_q     <= decode(head_inst);
        end else if (out_valid && out_ready) begin
            // Slot drains with nothing behind it; data fields hold.
            out_valid <= 1'b0;
        end
    end

    assign out_opcode  = dec_q.opcode;
    assign out_rd      = dec_q.rd;
    assign out_rs1     = dec_q.rs1;
    assign out_rs2     = dec_q.rs2;
    assign out_funct3  = dec_q.funct3;
    assign out_funct7  = dec_q.funct7;
    assign out_fmt     = dec_q.fmt;
    assign out_imm     = dec_q.imm;
    assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_inst_decoder.sv
module tb_inst_decoder;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 64;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_inst;
    logic          in_ready, out_valid, out_illegal;
    logic [AW-1:0] out_pc;
    logic [6:0]    out_opcode, out_funct7;
    logic [4:0]    out_rd, out_rs1, out_rs2;
    logic [2:0]    out_funct3, out_fmt;
    logic [63:0]   out_imm;

    always #5 clk = ~clk;

    inst_decoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_addr(in_addr), .in_inst(in_inst),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_fmt(out_fmt), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    exp_t slot;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.v = 0; e.pc = 0; e.opcode = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
        e.f3 = 0; e.f7 = 0; e.fmt = FMT_ILL; e.imm = 0; e.ill = 0;
        return e;
    endfunction

    // Spec-level decode: format from the opcode table, immediate as a signed
    // integer assembled from the listed bit groups.
    function automatic exp_t model_decode(input logic [63:0] pc, input logic [31:0] i);
        exp_t   e;
        longint imm;
        e.v = 1; e.pc = pc; e.opcode = i[6:0]; e.rd = i[11:7];
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = i[14:12]; e.f7 = i[31:25];
        e.ill = 0;
        imm = 0;
        case (i[6:0])
            7'h33, 7'h3B: e.fmt = FMT_R;
            7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                e.fmt = FMT_I; imm = longint'($signed(i[31:20]));
            end
            7'h23: begin e.fmt = FMT_S; imm = longint'($signed({i[31:25], i[11:7]})); end
            7'h63: begin
                e.fmt = FMT_B;
                imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin e.fmt = FMT_U; imm = longint'($signed(i[31:12])) * 4096; end
            7'h6F: begin
                e.fmt = FMT_J;
                imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            default: begin e.fmt = FMT_ILL; e.ill = 1; end
        endcase
        if (i == 32'd0) begin e.fmt = FMT_ILL; e.ill = 1; imm = 0; end
        e.imm = imm;
        return e;
    endfunction

    task automatic model_step();
        bit   full;
        ent_t h;
        if (reset || flush) begin
            q.delete();
            slot = reset_exp();
        end else begin
            full = (q.size() == DEPTH);
            if (q.size() > 0 && (!slot.v || out_ready)) begin
                h = q.pop_front();
                slot = model_decode(h.pc, h.inst);
            end else if (slot.v && out_ready) begin
                slot.v = 0;
            end
            if (in_valid && !full) begin
                h.pc = in_addr; h.inst = in_inst;
                q.push_back(h);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", out_valid, slot.v);
            chk("in_ready", in_ready, (q.size() < DEPTH));
            chk("out_pc", out_pc, slot.pc);
            chk("out_opcode", out_opcode, slot.opcode);
            chk("out_rd", out_rd, slot.rd);
            chk("out_rs1", out_rs1, slot.rs1);
            chk("out_rs2", out_rs2, slot.rs2);
            chk("out_funct3", out_funct3, slot.f3);
            chk("out_funct7", out_funct7, slot.f7);
            chk("out_fmt", out_fmt, slot.fmt);
            chk("out_imm", out_imm, slot.imm);
            chk("out_illegal", out_illegal, slot.ill);
        end
    end

    task automatic flush_test(input bit use_rst);
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_addr = 64'h5000 + 64'(4 * i); in_inst = 32'h00100013 | (32'(i) << 7);
            cyc();
        end
        chk("pre_flush_valid", out_valid, 1'b1);
        in_addr = 64'h5FFC; in_inst = 32'h00700093;
        if (use_rst) reset = 1; else flush = 1;
        cyc();
        reset = 0; flush = 0; in_valid = 0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        chk("flush_fmt", out_fmt, FMT_ILL);
        out_ready = 1;
        cyc(); cyc();
        chk("flush_dropped", out_valid, 1'b0);
    endtask

    logic [31:0] s_inst [4];
    logic [63:0] s_imm  [4];
    logic [63:0] seen[$];
    logic [6:0]  opc_tab [14];

    initial begin
        exp_t e;
        reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_addr = 0; in_inst = 0;

        e = model_decode(0, 32'hFFF00093); chk("pin_imm_i", e.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        e = model_decode(0, 32'h0020A423); chk("pin_imm_s", e.imm, 64'h8);
        e = model_decode(0, 32'hFE000EE3); chk("pin_imm_b", e.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        e = model_decode(0, 32'h123452B7); chk("pin_imm_u", e.imm, 64'h0000_0000_1234_5000);
        e = model_decode(0, 32'h800000EF); chk("pin_imm_j", e.imm, 64'hFFFF_FFFF_FFF0_0000);
        chk("pin_fmt_j", e.fmt, 3'd5);

        @(negedge clk);
        cyc(); cyc();
        check_en = 1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_fmt", out_fmt, 3'd6);
        chk("rst_imm", out_imm, 64'h0);
        chk("rst_ill", out_illegal, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        reset = 0;

        out_ready = 1; in_valid = 1; in_addr = 64'h1000; in_inst = 32'h00500093;
        cyc();
        in_valid = 0;
        cyc();
        chk("first_valid", out_valid, 1'b1);
        chk("first_opcode", out_opcode, 7'h13);
        chk("first_rd", out_rd, 5'd1);
        chk("first_rs1", out_rs1, 5'd0);
        chk("first_fmt", out_fmt, 3'd1);
        chk("first_imm", out_imm, 64'h5);
        chk("first_pc", out_pc, 64'h1000);

        s_inst[0] = 32'hFFF00093; s_imm[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        s_inst[1] = 32'h0020A423; s_imm[1] = 64'h8;
        s_inst[2] = 32'hFE000EE3; s_imm[2] = 64'hFFFF_FFFF_FFFF_FFFC;
        s_inst[3] = 32'h123452B7; s_imm[3] = 64'h0000_0000_1234_5000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_addr = 64'h2000 + 64'(4 * i); in_inst = s_inst[i];
            cyc();
            if (i > 0) chk("stream_imm", out_imm, s_imm[i-1]);
        end
        in_valid = 0;
        cyc();
        chk("stream_imm_last", out_imm, s_imm[3]);
        chk("stream_pc_last", out_pc, 64'h200C);
        cyc();

        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_addr = 64'h3000 + 64'(4 * i); in_inst = 32'h00000013 | (32'(i) << 7);
            cyc();
        end
        chk("bp_full_ready", in_ready, 1'b0);
        in_addr = 64'h3014; in_inst = 32'h00000013 | (32'd5 << 7);
        cyc();
        chk("bp_held_ready", in_ready, 1'b0);
        chk("bp_slot_pc", out_pc, 64'h3000);
        out_ready = 1;
        seen.delete();
        for (int c = 0; c < 20 && seen.size() < 6; c++) begin
            if (out_valid) seen.push_back(out_pc);
            cyc();
            if (c == 0) chk("full_pop_ready", in_ready, 1'b1);
            if (c == 1) in_valid = 0;
        end
        in_valid = 0;
        chk("bp_count", 64'(seen.size()), 64'd6);
        for (int i = 0; i < 6 && i < seen.size(); i++)
            chk("bp_order", seen[i], 64'h3000 + 64'(4 * i));

        in_valid = 1; in_addr = 64'h4000; in_inst = 32'h00000000;
        cyc();
        in_addr = 64'h4004; in_inst = 32'h0000007F;
        cyc();
        chk("ill0_flag", out_illegal, 1'b1);
        chk("ill0_fmt", out_fmt, 3'd6);
        chk("ill0_imm", out_imm, 64'h0);
        chk("ill0_pc", out_pc, 64'h4000);
        in_valid = 0;
        cyc();
        chk("ill7f_flag", out_illegal, 1'b1);
        chk("ill7f_fmt", out_fmt, 3'd6);
        chk("ill7f_imm", out_imm, 64'h0);
        chk("ill7f_pc", out_pc, 64'h4004);
        cyc();

        flush_test(1'b0);
        flush_test(1'b1);

        opc_tab = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                    7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h5B};
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            in_addr   = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       in_inst = 32'h0;
                1:       in_inst = $urandom;
                default: in_inst = {$urandom_range(0, 32'h01FF_FFFF), opc_tab[$urandom_range(0, 13)]};
            endcase
            cyc();
        end
        reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
